// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pkg                                                      |
// | Description : Shared frame geometry, pixel width, feeder FSM states and    |
// |               colour-bar constants for the VGA pixel feeder.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_V_ACTIVE = 480;
    localparam int c_PIXEL_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [c_PIXEL_W-1:0] c_BAR_WHITE   = 24'hFFFFFF;
    localparam logic [c_PIXEL_W-1:0] c_BAR_YELLOW  = 24'hFFFF00;
    localparam logic [c_PIXEL_W-1:0] c_BAR_CYAN    = 24'h00FFFF;
    localparam logic [c_PIXEL_W-1:0] c_BAR_GREEN   = 24'h00FF00;
    localparam logic [c_PIXEL_W-1:0] c_BAR_MAGENTA = 24'hFF00FF;
    localparam logic [c_PIXEL_W-1:0] c_BAR_RED     = 24'hFF0000;
    localparam logic [c_PIXEL_W-1:0] c_BAR_BLUE    = 24'h0000FF;
    localparam logic [c_PIXEL_W-1:0] c_BAR_BLACK   = 24'h000000;

    function automatic logic [c_PIXEL_W-1:0] bar_colour(input logic [2:0] idx);
        logic [c_PIXEL_W-1:0] colour;
        case (idx)
            3'd0:    colour = c_BAR_WHITE;
            3'd1:    colour = c_BAR_YELLOW;
            3'd2:    colour = c_BAR_CYAN;
            3'd3:    colour = c_BAR_GREEN;
            3'd4:    colour = c_BAR_MAGENTA;
            3'd5:    colour = c_BAR_RED;
            3'd6:    colour = c_BAR_BLUE;
            default: colour = c_BAR_BLACK;
        endcase
        return colour;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_skid_fifo                                                |
// | Description : Small synchronous FIFO (DEPTH x WIDTH) with occupancy and    |
// |               synchronous flush; absorbs read returns while stalled.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH-1)) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (i_rd_en) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_pixel_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pixel_feeder                                             |
// | Description : Streams one frame per vsync fall from a fixed-latency frame  |
// |               buffer into the VGA pixel FIFO. Optional colour-bar source   |
// |               enabled by macro VGA_FEEDER_TEST_PATTERN_EN.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_pixel_feeder
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = c_H_ACTIVE,
    parameter int V_ACTIVE   = c_V_ACTIVE,
    parameter int ADDR_W     = 19,
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [c_PIXEL_W-1:0] fifo_din,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [c_PIXEL_W-1:0] mem_rdata,
    input  logic                 pat_en,
    output logic                 frame_busy,
    output logic                 frame_err
);

    localparam int c_NPIX  = H_ACTIVE * V_ACTIVE;
    localparam int c_CNT_W = $clog2(c_NPIX + 1);
    localparam int c_OCC_W = $clog2(SKID_DEPTH + 1);

    state_t               r_state;
    logic                 r_vsync_d;
    logic                 r_start;
    logic                 r_err;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [RD_LAT-1:0]    r_vpipe;

    logic [c_OCC_W-1:0]   w_occ;
    logic [c_OCC_W-1:0]   w_inflight;
    logic                 w_issue;
    logic                 w_flush;
    logic                 w_push;
    logic                 w_cap_wr;
    logic [c_PIXEL_W-1:0] w_cap_data;
    logic [c_PIXEL_W-1:0] w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_vpipe[i]);
        end
    end

    // Reads already in flight reserve their skid slot, so a stalled FIFO can never overflow it.
    assign w_flush  = r_start && (r_state != IDLE);
    assign w_issue  = (r_state == FETCH) && !r_start &&
                      (((c_OCC_W+1)'(w_occ) + (c_OCC_W+1)'(w_inflight)) < (c_OCC_W+1)'(SKID_DEPTH));
    assign w_push   = (w_occ != '0) && !fifo_full && !r_start;
    assign w_cap_wr = r_vpipe[RD_LAT-1] && !w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vsync_d <= 1'b1;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_vpipe   <= '0;
        end else begin
            r_vsync_d  <= vsync;
            r_start    <= r_vsync_d && !vsync;
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end

            case (r_state)
                IDLE: begin
                    r_addr <= '0;
                    r_cnt  <= '0;
                    if (r_start) begin
                        r_state <= FETCH;
                    end
                end
                FETCH, DRAIN: begin
                    if (r_start) begin
                        r_err   <= 1'b1;
                        r_state <= FETCH;
                        r_addr  <= '0;
                        r_cnt   <= '0;
                        r_vpipe <= '0;
                    end else if (r_state == FETCH) begin
                        if (w_issue) begin
                            if (r_cnt == c_CNT_W'(c_NPIX - 1)) begin
                                r_state <= DRAIN;
                                r_addr  <= '0;
                            end else begin
                                r_addr <= r_addr + ADDR_W'(1);
                                r_cnt  <= r_cnt + c_CNT_W'(1);
                            end
                        end
                    end else if ((w_inflight == '0) && (w_occ == '0)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VGA_FEEDER_TEST_PATTERN_EN
    localparam int c_BAR_PIX = H_ACTIVE / 8;
    localparam int c_COL_W   = $clog2(H_ACTIVE);
    localparam int c_BPX_W   = $clog2(c_BAR_PIX + 1);

    logic               r_pat;
    logic [c_COL_W-1:0] r_col;
    logic [c_BPX_W-1:0] r_bar_px;
    logic [2:0]         r_bar;

    // Column tracking follows captured pixels, so bars stay aligned across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat    <= 1'b0;
            r_col    <= '0;
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (r_start) begin
            r_pat    <= pat_en;
            r_col    <= '0;
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (w_cap_wr) begin
            if (r_col == c_COL_W'(H_ACTIVE - 1)) begin
                r_col    <= '0;
                r_bar_px <= '0;
                r_bar    <= '0;
            end else begin
                r_col <= r_col + c_COL_W'(1);
                if (r_bar_px == c_BPX_W'(c_BAR_PIX - 1)) begin
                    r_bar_px <= '0;
                    r_bar    <= r_bar + 3'd1;
                end else begin
                    r_bar_px <= r_bar_px + c_BPX_W'(1);
                end
            end
        end
    end

    assign w_cap_data = r_pat ? bar_colour(r_bar) : mem_rdata;
`else
    logic w_pat_unused;
    assign w_pat_unused = pat_en;
    assign w_cap_data   = mem_rdata;
`endif

    vga_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (c_PIXEL_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_wr_en (w_cap_wr),
        .i_din   (w_cap_data),
        .i_rd_en (w_push),
        .o_dout  (w_head),
        .o_count (w_occ)
    );

    assign fifo_wr_en = w_push;
    assign fifo_din   = (w_occ != '0) ? w_head : '0;
    assign mem_rd_en  = w_issue;
    assign mem_addr   = r_addr;
    assign frame_busy = (r_state != IDLE);
    assign frame_err  = r_err;

endmodule
`default_nettype wire

// File: doc/vga_pixel_feeder.md
Name: vga_pixel_feeder

Overview:
Producer side of the 24-bit pixel FIFO that the VGA timing/output logic drains during active video. Once per frame, restarts on the vsync falling edge (vertical blank). Streams H_ACTIVE*V_ACTIVE pixels from a linear frame-buffer memory with fixed read latency into the FIFO. Never overflows the FIFO and never drops a pixel.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
ADDR_W, 19, frame-buffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)
RD_LAT, 2, cycles from mem_rd_en to valid mem_rdata (1..4)
SKID_DEPTH, 4, internal skid-buffer entries (must be >= RD_LAT+1)

Ports:
clk  in  1  system clock; single clock domain, shared with the VGA logic and FIFO
rst  in  1  synchronous, active-high reset
vsync  in  1  active-low vertical sync from the VGA timing logic
fifo_full  in  1  pixel FIFO full
fifo_wr_en  out  1  FIFO push strobe, one pixel per cycle
fifo_din  out  24  pixel {R[23:16],G[15:8],B[7:0]}
mem_rd_en  out  1  frame-buffer read request
mem_addr  out  ADDR_W  frame-buffer read address
mem_rdata  in  24  read data, valid exactly RD_LAT cycles after mem_rd_en
pat_en  in  1  select colour-bar pattern (see Optional Feature)
frame_busy  out  1  high while the current frame is still being fetched or drained
frame_err  out  1  sticky: a frame restarted before it had been completely pushed

Behaviour:
- Reset (synchronous, rst high at a clk edge): state=IDLE. fifo_wr_en, mem_rd_en, frame_busy and frame_err are 0. mem_addr=0, fifo_din=0. Skid buffer is empty. In-flight count is 0. Previous vsync is registered as 1.
- Frame start: the cycle after sampling vsync 1->0 (registered edge detect). Reads can only be issued after FETCH is entered, so the first mem_rd_en appears at least 1 cycle after that edge.
- FSM states:
  - IDLE: wait for frame start, then go to FETCH. Address=0, pixel count=0.
  - FETCH: assert mem_rd_en when (skid occupancy + in-flight reads) < SKID_DEPTH. mem_addr increments by 1 per issued read. After read number H_ACTIVE*V_ACTIVE has been issued, go to DRAIN.
  - DRAIN: stop issuing reads. Stay until the in-flight count is 0 and the skid buffer is empty, then go to IDLE.
- Return path: a shift pipe of RD_LAT valid bits tracks in-flight reads. When a valid bit emerges, mem_rdata is captured into the skid buffer (FIFO order).
- Push: fifo_wr_en=1 when the skid buffer is non-empty and fifo_full=0. The head entry is presented on fifo_din in the same cycle.
  - Push and capture in the same cycle are both performed; occupancy is unchanged.
  - The issue gate guarantees the skid buffer never overflows, even while fifo_full is held high indefinitely.
- frame_busy=1 in FETCH and DRAIN, 0 in IDLE.
- Frame start while not in IDLE (FIFO starved last frame):
  - set frame_err;
  - clear the skid buffer;
  - discard the remaining in-flight returns (the valid pipe is cleared);
  - restart FETCH at address 0.
- frame_err is cleared only by rst.
- Address wraps are impossible by construction; the count compare uses the full product width.
- Throughput: 1 pixel/cycle sustained when fifo_full=0, after an initial RD_LAT+1 cycle latency from the first read to the first push.

Optional Feature:
Macro VGA_FEEDER_TEST_PATTERN_EN.
- Defined, pat_en=1 (sampled at frame start): for the whole frame, the returned data is replaced by eight vertical colour bars, each H_ACTIVE/8 pixels wide. The bar colour is chosen by a column counter that wraps at H_ACTIVE.
  - Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - mem_rd_en, timing and flow control are identical to memory mode, with the substitution applied at capture.
- Not defined: pat_en is ignored and the pattern logic is absent.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults;
  - the pixel width (24);
  - the FSM state enum {IDLE, FETCH, DRAIN};
  - the eight colour-bar constants.
- One natural sub-module, vga_skid_fifo: a synchronous FIFO of SKID_DEPTH x 24 with occupancy output.

Test Plan:
- Reset, then a vsync falling edge with fifo_full=0 and memory holding data=address -> exactly 307200 pushes of 0x000000..0x04AFFF in order. frame_busy drops afterwards. frame_err=0.
- Hold fifo_full=1 for 50 cycles mid-frame -> outstanding reads plus skid entries never exceed 4. No pixel is lost or duplicated. Pushes resume the cycle after fifo_full falls.
- With RD_LAT=4, SKID_DEPTH=5 -> first fifo_wr_en 5 cycles after the first mem_rd_en. Sequence is correct.
- Second vsync falling edge at pixel 1000 of the frame -> frame_err=1. No stale data is pushed. The next push is the pixel from address 0.
- Assert rst mid-FETCH -> all outputs 0 on the next cycle. No push until the next vsync falling edge.
- With VGA_FEEDER_TEST_PATTERN_EN defined and pat_en=1 -> pixels 0..79 are FFFFFF, 80..159 are FFFF00, pixel 639 is 000000, and pixel 640 is FFFFFF.
